packet_picker: RTL and testbench

Upstream feeder of `packet_assembler` in the HDMI data-island path. Each time the assembler signals `packet_enable`, it selects the next packet: audio clock regeneration (ACR), audio sample, AVI / Audio / SPD InfoFrame, or null. It builds the 24-bit header and four 56-bit subpackets and holds them stable for the assembler. It also buffers incoming stereo audio samples and tracks the IEC 60958 192-frame block.

---
 rtl/hdmi_pkg.sv | 66 ++++++
 rtl/audio_sample_fifo.sv | 48 ++++
 rtl/packet_picker.sv | 233 +++++++++++++++++++++++
 tb/tb_packet_picker.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island definitions: packet headers, subpacket types and InfoFrame helpers.
// SPD constants exist only when HDMI_SPD_INFOFRAME_EN is defined.
package hdmi_pkg;

    typedef logic [55:0]      subpacket_t;
    typedef subpacket_t [3:0] sub_arr_t;
    typedef logic [27:0][7:0] pb_arr_t;

    typedef enum logic [2:0] {
        SEL_NULL,
        SEL_ACR,
        SEL_AUDIO,
        SEL_AVI,
        SEL_AIF,
        SEL_SPD
    } pkt_sel_t;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI          = 8'h82;
    localparam logic [7:0] PKT_AIF          = 8'h84;

    localparam logic [7:0] AVI_VER = 8'h02;
    localparam logic [7:0] AVI_LEN = 8'd13;
    localparam logic [7:0] AIF_VER = 8'h01;
    localparam logic [7:0] AIF_LEN = 8'd10;

    localparam logic [23:0] HDR_NULL = {16'h0000, PKT_NULL};
    localparam logic [23:0] HDR_ACR  = {16'h0000, PKT_ACR};
    localparam logic [23:0] HDR_AVI  = {AVI_LEN, AVI_VER, PKT_AVI};
    localparam logic [23:0] HDR_AIF  = {AIF_LEN, AIF_VER, PKT_AIF};

`ifdef HDMI_SPD_INFOFRAME_EN
    localparam logic [7:0]  PKT_SPD    = 8'h83;
    localparam logic [7:0]  SPD_VER    = 8'h01;
    localparam logic [7:0]  SPD_LEN    = 8'd25;
    localparam logic [23:0] HDR_SPD    = {SPD_LEN, SPD_VER, PKT_SPD};
    localparam logic [63:0] SPD_VENDOR = "hdl-util";
`endif

    // PB0 is the byte that brings HB0..HB2 plus every payload byte to 0 mod 256.
    function automatic logic [7:0] infoframe_checksum(input logic [23:0] hdr, input pb_arr_t pb);
        logic [7:0] sum;
        sum = hdr[7:0] + hdr[15:8] + hdr[23:16];
        for (int i = 1; i < 28; i++) begin
            sum = sum + pb[i];
        end
        return 8'h00 - sum;
    endfunction

    function automatic sub_arr_t build_infoframe(input logic [23:0] hdr, input pb_arr_t body);
        pb_arr_t  pb;
        sub_arr_t s;
        pb    = body;
        pb[0] = infoframe_checksum(hdr, body);
        s     = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 7; k++) begin
                s[i][8*k +: 8] = pb[5'(7*i + k)];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// 8 x 48-bit sample FIFO with one push and a multi-pop of up to four entries per cycle.
// The four oldest entries are presented in parallel so a whole audio packet can be built at once.
module audio_sample_fifo
    import hdmi_pkg::*;
(
    input  logic            clk_pixel,
    input  logic            reset,
    input  logic            push,
    input  logic [47:0]     push_data,
    input  logic [2:0]      pop_n,
    output logic [3:0]      count,
    output logic            full,
    output logic [3:0][47:0] head_data
);

    logic [47:0] mem [8];
    logic [2:0]  rd_ptr;
    logic [2:0]  wr_ptr;

    always_ff @(posedge clk_pixel) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            rd_ptr <= rd_ptr + pop_n;
            count  <= count + 4'(push) - 4'(pop_n);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            head_data[i] = mem[rd_ptr + 3'(i)];
        end
    end

    assign full = (count == 4'd8);

endmodule

// File: rtl/packet_picker.sv
// Chooses the next HDMI data-island packet on each packet_enable and holds header/subpackets for the assembler.
// Define HDMI_SPD_INFOFRAME_EN to add the once-per-field SPD InfoFrame.
module packet_picker
    import hdmi_pkg::*;
#(
    parameter int VIDEO_ID_CODE   = 1,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int ACR_N           = 6144,
    parameter int ACR_CTS         = 25200,
    parameter int ACR_PERIOD      = 25200
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        video_field_end,
    input  logic        packet_enable,
    input  logic        audio_sample_valid,
    input  logic [47:0] audio_sample_word,
    output logic        audio_sample_ready,
    output logic [23:0] header,
    output sub_arr_t    sub
);

    if (AUDIO_BIT_WIDTH < 16 || AUDIO_BIT_WIDTH > 24) begin : g_bad_width
        $error("AUDIO_BIT_WIDTH must lie in 16..24");
    end

    localparam int         CNT_W   = (ACR_PERIOD > 1) ? $clog2(ACR_PERIOD) : 1;
    localparam logic [6:0] VIC7    = 7'(VIDEO_ID_CODE);
    localparam logic [19:0] ACR_N20   = 20'(ACR_N);
    localparam logic [19:0] ACR_CTS20 = 20'(ACR_CTS);

    // PB0 = 0, then CTS and N each as {4'b0, bits[19:16]}, bits[15:8], bits[7:0].
    localparam subpacket_t ACR_SUB = {ACR_N20[7:0], ACR_N20[15:8], 4'h0, ACR_N20[19:16],
                                      ACR_CTS20[7:0], ACR_CTS20[15:8], 4'h0, ACR_CTS20[19:16],
                                      8'h00};

    function automatic pb_arr_t avi_body();
        pb_arr_t pb;
        pb    = '0;
        pb[2] = 8'h08;
        pb[4] = {1'b0, VIC7};
        return pb;
    endfunction

    function automatic pb_arr_t aif_body();
        pb_arr_t pb;
        pb    = '0;
        pb[1] = 8'h01;
        return pb;
    endfunction

    localparam sub_arr_t AVI_SUB = build_infoframe(HDR_AVI, avi_body());
    localparam sub_arr_t AIF_SUB = build_infoframe(HDR_AIF, aif_body());

`ifdef HDMI_SPD_INFOFRAME_EN
    function automatic pb_arr_t spd_body();
        pb_arr_t pb;
        pb = '0;
        for (int i = 0; i < 8; i++) begin
            pb[5'(i + 1)] = SPD_VENDOR[8*(7-i) +: 8];
        end
        return pb;
    endfunction

    localparam sub_arr_t SPD_SUB = build_infoframe(HDR_SPD, spd_body());
`endif

    function automatic logic sample_parity(input logic [23:0] s);
        return ^s;
    endfunction

    function automatic logic [7:0] frame_add(input logic [7:0] f, input logic [2:0] n);
        logic [8:0] t;
        t = {1'b0, f} + {6'b000000, n};
        return (t >= 9'd192) ? 8'(t - 9'd192) : t[7:0];
    endfunction

    logic             ready_q;
    logic             acr_pending;
    logic             avi_pending;
    logic             aif_pending;
`ifdef HDMI_SPD_INFOFRAME_EN
    logic             spd_pending;
`endif
    logic [CNT_W-1:0] acr_cnt;
    logic             acr_wrap;
    logic [7:0]       frame_idx;

    logic             fifo_push;
    logic [2:0]       fifo_pop_n;
    logic [3:0]       fifo_count;
    logic             fifo_full;
    logic [3:0][47:0] fifo_head;

    pkt_sel_t         sel_p0;
    logic [2:0]       pop_cnt_p0;
    logic [3:0]       aud_present_p0;
    logic [3:0]       aud_b_p0;
    sub_arr_t         aud_sub_p0;
    logic [23:0]      nxt_header_p0;
    sub_arr_t         nxt_sub_p0;

    assign audio_sample_ready = reset && ready_q && !fifo_full;
    assign fifo_push          = audio_sample_valid && audio_sample_ready;
    assign fifo_pop_n         = (packet_enable && sel_p0 == SEL_AUDIO) ? pop_cnt_p0 : 3'd0;
    assign acr_wrap           = (acr_cnt == CNT_W'(ACR_PERIOD - 1));

    audio_sample_fifo u_fifo (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (audio_sample_word),
        .pop_n     (fifo_pop_n),
        .count     (fifo_count),
        .full      (fifo_full),
        .head_data (fifo_head)
    );

    // p0: select packet and assemble its contents from the current state
    always_comb begin
        sel_p0 = SEL_NULL;
        if (acr_pending) begin
            sel_p0 = SEL_ACR;
        end else if (fifo_count != 4'd0) begin
            sel_p0 = SEL_AUDIO;
        end else if (avi_pending) begin
            sel_p0 = SEL_AVI;
        end else if (aif_pending) begin
            sel_p0 = SEL_AIF;
        end
`ifdef HDMI_SPD_INFOFRAME_EN
        else if (spd_pending) begin
            sel_p0 = SEL_SPD;
        end
`endif
    end

    always_comb begin
        logic [23:0] left_s;
        logic [23:0] right_s;
        pop_cnt_p0     = (fifo_count > 4'd4) ? 3'd4 : fifo_count[2:0];
        aud_present_p0 = '0;
        aud_b_p0       = '0;
        aud_sub_p0     = '0;
        left_s         = '0;
        right_s        = '0;
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < pop_cnt_p0) begin
                left_s            = fifo_head[j][23:0];
                right_s           = fifo_head[j][47:24];
                aud_present_p0[j] = 1'b1;
                aud_b_p0[j]       = (frame_add(frame_idx, 3'(j)) == 8'd0);
                aud_sub_p0[j]     = {sample_parity(right_s), 3'b000,
                                     sample_parity(left_s), 3'b000, right_s, left_s};
            end
        end
    end

    always_comb begin
        nxt_header_p0 = HDR_NULL;
        nxt_sub_p0    = '0;
        unique case (sel_p0)
            SEL_ACR: begin
                nxt_header_p0 = HDR_ACR;
                nxt_sub_p0    = {ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB};
            end
            SEL_AUDIO: begin
                nxt_header_p0 = {aud_b_p0, 4'b0000, 4'b0000, aud_present_p0, PKT_AUDIO_SAMPLE};
                nxt_sub_p0    = aud_sub_p0;
            end
            SEL_AVI: begin
                nxt_header_p0 = HDR_AVI;
                nxt_sub_p0    = AVI_SUB;
            end
            SEL_AIF: begin
                nxt_header_p0 = HDR_AIF;
                nxt_sub_p0    = AIF_SUB;
            end
`ifdef HDMI_SPD_INFOFRAME_EN
            SEL_SPD: begin
                nxt_header_p0 = HDR_SPD;
                nxt_sub_p0    = SPD_SUB;
            end
`endif
            default: ;
        endcase
    end

    // p1: registered packet outputs and bookkeeping; event sets win over same-cycle clears
    always_ff @(posedge clk_pixel) begin
        if (!reset) begin
            ready_q     <= 1'b0;
            acr_pending <= 1'b0;
            avi_pending <= 1'b0;
            aif_pending <= 1'b0;
`ifdef HDMI_SPD_INFOFRAME_EN
            spd_pending <= 1'b0;
`endif
            acr_cnt     <= '0;
            frame_idx   <= '0;
            header      <= '0;
            sub         <= '0;
        end else begin
            ready_q <= 1'b1;
            acr_cnt <= acr_wrap ? '0 : acr_cnt + 1'b1;
            if (packet_enable) begin
                header <= nxt_header_p0;
                sub    <= nxt_sub_p0;
                unique case (sel_p0)
                    SEL_ACR:   acr_pending <= 1'b0;
                    SEL_AUDIO: frame_idx   <= frame_add(frame_idx, pop_cnt_p0);
                    SEL_AVI:   avi_pending <= 1'b0;
                    SEL_AIF:   aif_pending <= 1'b0;
`ifdef HDMI_SPD_INFOFRAME_EN
                    SEL_SPD:   spd_pending <= 1'b0;
`endif
                    default: ;
                endcase
            end
            if (acr_wrap) begin
                acr_pending <= 1'b1;
            end
            if (video_field_end) begin
                avi_pending <= 1'b1;
                aif_pending <= 1'b1;
`ifdef HDMI_SPD_INFOFRAME_EN
                spd_pending <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_packet_picker.sv
// Self-checking bench for packet_picker: directed scenarios plus random traffic against a queue-based model.
module tb_packet_picker;

    localparam int VIC    = 1;
    localparam int ABW    = 16;
    localparam int N_VAL  = 6144;
    localparam int CTS    = 25200;
    localparam int PERIOD = 25200;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             video_field_end = 1'b0;
    logic             packet_enable = 1'b0;
    logic             audio_sample_valid = 1'b0;
    logic [47:0]      audio_sample_word = '0;
    logic             audio_sample_ready;
    logic [23:0]      header;
    logic [3:0][55:0] sub;

    always #5 clk = ~clk;

    packet_picker #(
        .VIDEO_ID_CODE   (VIC),
        .AUDIO_BIT_WIDTH (ABW),
        .ACR_N           (N_VAL),
        .ACR_CTS         (CTS),
        .ACR_PERIOD      (PERIOD)
    ) dut (
        .clk_pixel          (clk),
        .reset              (reset),
        .video_field_end    (video_field_end),
        .packet_enable      (packet_enable),
        .audio_sample_valid (audio_sample_valid),
        .audio_sample_word  (audio_sample_word),
        .audio_sample_ready (audio_sample_ready),
        .header             (header),
        .sub                (sub)
    );

    // Reference model state
    logic [47:0]      mq[$];
    bit               m_acr, m_avi, m_aif, m_spd, m_rdy;
    int               m_cnt, m_frame;
    logic [23:0]      e_hdr;
    logic [3:0][55:0] e_sub;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [223:0] got, input logic [223:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0][55:0] pack(input logic [7:0] pb [28]);
        logic [3:0][55:0] s;
        s = '0;
        for (int i = 0; i < 28; i++) s[i/7][(i%7)*8 +: 8] = pb[i];
        return s;
    endfunction

    function automatic logic [3:0][55:0] infoframe(input logic [23:0] hdr, input logic [7:0] pb [28]);
        logic [7:0] q [28];
        int sum;
        q   = pb;
        sum = int'(hdr[7:0]) + int'(hdr[15:8]) + int'(hdr[23:16]);
        for (int i = 1; i < 28; i++) sum += int'(q[i]);
        q[0] = 8'((256 - sum % 256) % 256);
        return pack(q);
    endfunction

    function automatic logic [47:0] rnd_sample();
        logic [47:0] w;
        w[31:0]  = $urandom();
        w[47:32] = 16'($urandom());
        // left-aligned 16-bit samples: the low byte of each channel is zero
        w[7:0]   = 8'h00;
        w[31:24] = 8'h00;
        return w;
    endfunction

    task automatic model_edge();
        bit          push;
        int          k;
        logic [7:0]  pb [28];
        logic [47:0] w;
        logic [23:0] l, r;
        bit          pl, pr;
        logic [3:0]  present, b;
        logic [3:0][55:0] s;
        if (!reset) begin
            mq.delete();
            m_acr = 0; m_avi = 0; m_aif = 0; m_spd = 0; m_rdy = 0;
            m_cnt = 0; m_frame = 0;
            e_hdr = '0; e_sub = '0;
            return;
        end
        push = audio_sample_valid && m_rdy && (mq.size() < 8);
        if (packet_enable) begin
            e_hdr = '0;
            e_sub = '0;
            foreach (pb[i]) pb[i] = 8'h00;
            if (m_acr) begin
                m_acr = 0;
                pb[1] = {4'h0, 4'(CTS >> 16)}; pb[2] = 8'(CTS >> 8); pb[3] = 8'(CTS);
                pb[4] = {4'h0, 4'(N_VAL >> 16)}; pb[5] = 8'(N_VAL >> 8); pb[6] = 8'(N_VAL);
                s = pack(pb);
                e_sub = {s[0], s[0], s[0], s[0]};
                e_hdr = 24'h000001;
            end else if (mq.size() > 0) begin
                k = (mq.size() > 4) ? 4 : mq.size();
                present = '0;
                b = '0;
                for (int j = 0; j < k; j++) begin
                    w  = mq.pop_front();
                    l  = w[23:0];
                    r  = w[47:24];
                    pl = ($countones(l) % 2) == 1;
                    pr = ($countones(r) % 2) == 1;
                    e_sub[j]   = {pr, 3'b000, pl, 3'b000, r, l};
                    present[j] = 1'b1;
                    b[j]       = ((m_frame + j) % 192) == 0;
                end
                m_frame = (m_frame + k) % 192;
                e_hdr = {b, 4'h0, 4'h0, present, 8'h02};
            end else if (m_avi) begin
                m_avi = 0;
                pb[2] = 8'h08;
                pb[4] = 8'(VIC);
                e_hdr = 24'h0D0282;
                e_sub = infoframe(e_hdr, pb);
            end else if (m_aif) begin
                m_aif = 0;
                pb[1] = 8'h01;
                e_hdr = 24'h0A0184;
                e_sub = infoframe(e_hdr, pb);
            end
`ifdef HDMI_SPD_INFOFRAME_EN
            else if (m_spd) begin
                string vendor;
                m_spd  = 0;
                vendor = "hdl-util";
                for (int i = 0; i < 8; i++) pb[i+1] = vendor[i];
                e_hdr = 24'h190183;
                e_sub = infoframe(e_hdr, pb);
            end
`endif
        end
        if (push) mq.push_back(audio_sample_word);
        if (m_cnt == PERIOD - 1) begin
            m_acr = 1;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        if (video_field_end) begin
            m_avi = 1; m_aif = 1; m_spd = 1;
        end
        m_rdy = 1;
    endtask

    task automatic cycle(input bit en, input bit fe, input bit vld, input logic [47:0] w);
        packet_enable      = en;
        video_field_end    = fe;
        audio_sample_valid = vld;
        audio_sample_word  = w;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("ready", 224'(audio_sample_ready), 224'(reset && m_rdy && (mq.size() < 8)));
        if (en || !reset || (cyc % 16) == 0) begin
            chk("header", 224'(header), 224'(e_hdr));
            chk("sub", sub, e_sub);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 48'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         sum;
        int         s_popped;
        int         pushed;
        int         n;
        logic [19:0] f;
        logic [23:0] exp_third;

        // Reset behaviour and first slot
        reset = 1'b0;
        idle(3);
        chk("rst_header", 224'(header), 224'h0);
        chk("rst_sub", sub, 224'h0);
        chk("rst_ready", 224'(audio_sample_ready), 224'h0);
        reset = 1'b1;
        idle(1);
        chk("ready_after_rst", 224'(audio_sample_ready), 224'h1);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("first_slot_null", 224'(header), 224'h0);

        // InfoFrames after a field end
        cycle(1'b0, 1'b1, 1'b0, 48'h0);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("avi_hdr", 224'(header), 224'h0D0282);
        sum = int'(header[7:0]) + int'(header[15:8]) + int'(header[23:16]);
        for (int i = 0; i < 28; i++) sum += int'(sub[i/7][(i%7)*8 +: 8]);
        chk("avi_sum", 224'(sum % 256), 224'h0);
        chk("avi_pb4", 224'(sub[0][39:32]), 224'h1);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("aif_hdr", 224'(header), 224'h0A0184);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
`ifdef HDMI_SPD_INFOFRAME_EN
        exp_third = 24'h190183;
`else
        exp_third = 24'h000000;
`endif
        chk("third_hdr", 224'(header), 224'(exp_third));

        // Six samples drained by two packets
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, rnd_sample());
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("hb1_first", 224'(header[15:8]), 224'h0F);
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("hb1_second", 224'(header[15:8]), 224'h03);
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("fifo_drained", 224'(header), 224'h0);

        // Parity of a single set bit in the left channel
        cycle(1'b0, 1'b0, 1'b1, {24'h000000, 24'h000001});
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("parity_byte", 224'(sub[0][55:48]), 224'h08);

        // IEC block start flag across 193 samples from a fresh reset
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        s_popped = 0;
        pushed   = 0;
        for (int r = 0; r < 60 && s_popped < 193; r++) begin
            n = (193 - pushed > 4) ? 4 : 193 - pushed;
            for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, rnd_sample());
            pushed += n;
            cycle(1'b1, 1'b0, 1'b0, 48'h0);
            for (int j = 0; j < 4; j++) begin
                if (header[8+j]) begin
                    chk("iec_b", 224'(header[20+j]), 224'(s_popped == 0 || s_popped == 192));
                    s_popped++;
                end
            end
        end
        chk("iec_count", 224'(s_popped), 224'd193);

        // ACR takes priority over queued samples and a pending AVI
        cycle(1'b0, 1'b0, 1'b1, rnd_sample());
        cycle(1'b0, 1'b1, 1'b1, rnd_sample());
        idle(PERIOD);
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("acr_hdr", 224'(header), 224'h000001);
        f = {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
        chk("acr_cts", 224'(f), 224'(CTS));
        f = {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
        chk("acr_n", 224'(f), 224'(N_VAL));
        chk("acr_pb0", 224'(sub[0][7:0]), 224'h0);
        chk("acr_sub3", 224'(sub[3]), 224'h00180070620000);
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("after_acr_audio", 224'(header[7:0]), 224'h02);
        cycle(1'b1, 1'b0, 1'b0, 48'h0);
        chk("then_avi", 224'(header), 224'h0D0282);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 1499) != 0);
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0,
                  $urandom_range(0, 1) == 1, rnd_sample());
        end
        reset = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
